// File: rtl/sa_pkg.sv
// Shared systolic-array constants, feeder state type and lane slicing helper.
package sa_pkg;

  localparam int SA_DATA_W = 8;
  localparam int SA_N      = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } feed_state_t;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DELAY-deep {valid, data} register chain used to skew one feeder lane.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int DELAY  = 1,
  parameter int DATA_W = SA_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  if (DELAY == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, reset};
    assign valid = src_valid;
    assign data  = src_data;
  end else begin : g_chain
    logic [DELAY-1:0]             v_q;
    logic [DELAY-1:0][DATA_W-1:0] d_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q[0] <= src_valid;
        d_q[0] <= src_data;
        for (int i = 1; i < DELAY; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign valid = v_q[DELAY-1];
    assign data  = d_q[DELAY-1];
  end

endmodule

// File: rtl/sa_row_feeder.sv
// Vector FIFO + diagonal skew feeder for the PE rows; N-1 zero cycles after last.
// SA_FEEDER_PERF_EN adds a saturating 16-bit bubble_count output.
module sa_row_feeder
  import sa_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int DATA_W = SA_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_last,
  output logic [N*DATA_W-1:0] lane_data,
  output logic [N-1:0]        lane_valid,
  output logic                busy,
  output logic                done
`ifdef SA_FEEDER_PERF_EN
  ,
  output logic [15:0]         bubble_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = N * DATA_W + 1;
  localparam int CW = $clog2(N);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, fill;
  logic          empty, full, push, pop;
  logic [EW-1:0] head;

  assign fill     = wr_ptr - rd_ptr;
  assign empty    = (fill == '0);
  assign full     = (fill == (AW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
    end
  end

  feed_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          done_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE, STREAM: begin
        if (!empty) begin
          pop = 1'b1;
          if (head[EW-1]) begin
            state_nx = FLUSH;
            cnt_nx   = CW'(N - 2);
          end else begin
            state_nx = STREAM;
          end
        end
      end
      FLUSH: begin
        // final flush edge lines up with the last vector reaching lane N-1
        if (cnt == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  logic                stage_valid;
  logic [N*DATA_W-1:0] stage_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= pop;
      stage_data  <= pop ? head[EW-2:0] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    sa_skew_line #(
      .DELAY (i),
      .DATA_W(DATA_W)
    ) u_skew (
      .clk      (clk),
      .reset    (reset),
      .src_valid(stage_valid),
      .src_data (stage_data[lane_lo(i, DATA_W) +: DATA_W]),
      .valid    (lane_valid[i]),
      .data     (lane_data[lane_lo(i, DATA_W) +: DATA_W])
    );
  end

`ifdef SA_FEEDER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (state == IDLE && pop) begin
      bubble_count <= '0;
    end else if (state == STREAM && empty && bubble_count != 16'hFFFF) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_row_feeder.sv
// Directed bench for sa_row_feeder: reset, skew timing, underflow, full FIFO.
module tb_sa_row_feeder;
  import sa_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic           in_ready;
  logic [N*W-1:0] lane_data;
  logic [N-1:0]   lane_valid;
  logic           busy;
  logic           done;
`ifdef SA_FEEDER_PERF_EN
  logic [15:0]    bubble_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sa_row_feeder #(.N(N), .DATA_W(W), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .lane_data (lane_data),
    .lane_valid(lane_valid),
    .busy      (busy),
    .done      (done)
`ifdef SA_FEEDER_PERF_EN
    ,
    .bubble_count(bubble_count)
`endif
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic single_vec();
    in_valid = 1'b1;
    in_data  = 32'h04030201;
    in_last  = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    chk("sv_k_valid", 32'(lane_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sv_valid", 32'(lane_valid), 32'(1) << i);
      chk("sv_data", lane_data, 32'(i + 1) << (8 * i));
      chk("sv_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
      if (i == 0) chk("sv_busy_hi", 32'(busy), 32'h1);
    end
    cyc();
    chk("sv_done_low", 32'(done), 32'h0);
    chk("sv_busy_low", 32'(busy), 32'h0);
    chk("sv_idle_valid", 32'(lane_valid), 32'h0);
  endtask

  initial begin
    // reset state
    cyc();
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_valid", 32'(lane_valid), 32'h0);
    chk("rst_data", lane_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_valid", 32'(lane_valid), 32'h0);
    end

    single_vec();

    // back-to-back A, B, C(last)
    in_valid = 1'b1;
    in_data  = 32'h14131211;
    cyc();
    in_data = 32'h24232221;
    cyc();
    chk("b2b_lane0_a", 32'(lane_data[7:0]), 32'h11);
    in_data = 32'h34333231;
    in_last = 1'b1;
    cyc();
    chk("b2b_lane0_b", 32'(lane_data[7:0]), 32'h21);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc();
    chk("b2b_diag3", lane_data, 32'h00132231);
    chk("b2b_valid3", 32'(lane_valid), 32'h7);
    cyc();
    chk("b2b_diag4", lane_data, 32'h14233200);
    chk("b2b_valid4", 32'(lane_valid), 32'he);
    chk("b2b_done4", 32'(done), 32'h0);
    cyc();
    chk("b2b_diag5", lane_data, 32'h24330000);
    chk("b2b_done5", 32'(done), 32'h0);
    cyc();
    chk("b2b_diag6", lane_data, 32'h34000000);
    chk("b2b_valid6", 32'(lane_valid), 32'h8);
    chk("b2b_done6", 32'(done), 32'h1);
    cyc();
    chk("b2b_done7", 32'(done), 32'h0);
    chk("b2b_valid7", 32'(lane_valid), 32'h0);

    // underflow: A, two idle cycles, B(last)
    in_valid = 1'b1;
    in_data  = 32'h44434241;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("uf_a", 32'(lane_data[7:0]), 32'h41);
    chk("uf_a_v", 32'(lane_valid[0]), 32'h1);
    cyc();
    chk("uf_bub1", 32'(lane_data[7:0]), 32'h0);
    chk("uf_bub1_v", 32'(lane_valid[0]), 32'h0);
    in_valid = 1'b1;
    in_data  = 32'h54535251;
    in_last  = 1'b1;
    cyc();
    chk("uf_bub2", 32'(lane_data[7:0]), 32'h0);
    chk("uf_bub2_v", 32'(lane_valid[0]), 32'h0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc();
    chk("uf_b_diag", lane_data, 32'h44000051);
    chk("uf_b_valid", 32'(lane_valid), 32'h9);
`ifdef SA_FEEDER_PERF_EN
    chk("uf_bubbles", 32'(bubble_count), 32'h2);
`endif
    cyc();
    cyc();
    cyc();
    chk("uf_done", 32'(done), 32'h1);
    chk("uf_last", lane_data, 32'h54000000);
    cyc();
    chk("uf_done_low", 32'(done), 32'h0);

    // full FIFO while the previous matrix flushes
    in_valid = 1'b1;
    in_data  = 32'h64636261;
    in_last  = 1'b1;
    cyc();
    in_last = 1'b0;
    in_data = 32'h71717171;
    cyc();
    in_data = 32'h72727272;
    cyc();
    in_data = 32'h73737373;
    cyc();
    in_data = 32'h74747474;
    cyc();
    chk("ff_not_ready", 32'(in_ready), 32'h0);
    chk("ff_prev_done", 32'(done), 32'h1);
    in_data = 32'h75757575;
    in_last = 1'b1;
    cyc();
    chk("ff_ready_again", 32'(in_ready), 32'h1);
    chk("ff_v1", 32'(lane_data[7:0]), 32'h71);
    cyc();
    chk("ff_v2", 32'(lane_data[7:0]), 32'h72);
`ifdef SA_FEEDER_PERF_EN
    chk("ff_bubbles_clr", 32'(bubble_count), 32'h0);
`endif
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc();
    chk("ff_v3", 32'(lane_data[7:0]), 32'h73);
    cyc();
    chk("ff_v4", 32'(lane_data[7:0]), 32'h74);
    cyc();
    chk("ff_v5", 32'(lane_data[7:0]), 32'h75);
    chk("ff_v5_v", 32'(lane_valid[0]), 32'h1);
    cyc();
    chk("ff_no_dup", 32'(lane_valid[0]), 32'h0);
    cyc();
    cyc();
    chk("ff_done", 32'(done), 32'h1);
    chk("ff_last", lane_data, 32'h75000000);
    cyc();

    // reset in the middle of a stream
    in_valid = 1'b1;
    in_data  = 32'h83828180;
    cyc();
    in_data = 32'h93929190;
    cyc();
    in_data = 32'ha3a2a1a0;
    in_last = 1'b1;
    cyc();
    chk("mr_lane0_y", 32'(lane_data[7:0]), 32'h90);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    #1;
    chk("mr_data", lane_data, 32'h0);
    chk("mr_valid", 32'(lane_valid), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    chk("mr_ready", 32'(in_ready), 32'h1);
`ifdef SA_FEEDER_PERF_EN
    chk("mr_bubbles", 32'(bubble_count), 32'h0);
`endif
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mr_quiet_valid", 32'(lane_valid), 32'h0);
      chk("mr_quiet_done", 32'(done), 32'h0);
    end

    single_vec();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
